// File: rtl/text_pixel_renderer.sv
// Character-cell pixel renderer: maps raster position to a buffer cell, fetches the glyph
// row from the font ROM and resolves palette colours, with a blinking block cursor on code 127.
module text_pixel_renderer #(
    parameter int unsigned CORDW        = 10,
    parameter int unsigned GRID_COL     = 10,
    parameter int unsigned GRID_ROW     = 5,
    parameter int unsigned CH_W         = 8,
    parameter int unsigned CH_H         = 16,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned BUFFER_WIDTH = 16
) (
    input  logic                        clk_pix,
    input  logic                        rst_n,
    input  logic [CORDW-1:0]            sx,
    input  logic [CORDW-1:0]            sy,
    input  logic                        de,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    output logic [$clog2(GRID_COL)-1:0] chPos_x,
    output logic [$clog2(GRID_ROW)-1:0] chPos_y,
    input  logic [BUFFER_WIDTH-1:0]     bufferBundle,
    output logic [10:0]                 font_addr,
    input  logic [7:0]                  font_row,
    output logic [11:0]                 rgb,
    output logic                        de_out,
    output logic                        hsync_out,
    output logic                        vsync_out
);

    localparam int unsigned CX_W = $clog2(GRID_COL);
    localparam int unsigned CY_W = $clog2(GRID_ROW);
    localparam int unsigned PX_W = $clog2(CH_W);
    localparam int unsigned PY_W = $clog2(CH_H);
    localparam int unsigned FC_W = $clog2(BLINK_FRAMES);
    localparam logic [CORDW-1:0] GRID_W_PX = CORDW'(GRID_COL * CH_W);
    localparam logic [CORDW-1:0] GRID_H_PX = CORDW'(GRID_ROW * CH_H);

    function automatic logic [11:0] palette(input logic [3:0] idx);
        logic [11:0] c;
        case (idx)
            4'd0:    c = 12'h000;
            4'd1:    c = 12'h00F;
            4'd2:    c = 12'h0F0;
            4'd3:    c = 12'h0FF;
            4'd4:    c = 12'hF00;
            4'd5:    c = 12'hFFF;
            4'd6:    c = 12'hFF0;
            4'd7:    c = 12'hF0F;
            4'd8:    c = 12'h888;
            default: c = 12'h444;
        endcase
        return c;
    endfunction

    // Stage 1: cell address and intra-cell offsets
    logic            in1_d;
    logic [CX_W-1:0] chx_d, chx_q;
    logic [CY_W-1:0] chy_d, chy_q;
    logic [PX_W-1:0] px1_q, px2_q, px3_q;
    logic [PY_W-1:0] py1_q, py2_q;
    logic            in1_q, in2_q, in3_q;
    // Sideband bundles: {de, hsync, vsync}
    logic [2:0]      sb1_q, sb2_q, sb3_q, sb4_q;
    logic [7:0]      ascii3_q;
    logic [3:0]      fg3_q, bg3_q;
    logic [11:0]     rgb_d, rgb_q;

    logic            vs_prev_q, vs_rise;
    logic [FC_W-1:0] frame_d, frame_q;
    logic            blink_d, blink_q;

    always_comb begin
        in1_d = (sx < GRID_W_PX) && (sy < GRID_H_PX);
        chx_d = in1_d ? CX_W'(sx >> PX_W) : '0;
        chy_d = in1_d ? CY_W'(sy >> PY_W) : '0;
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            chx_q    <= '0;
            chy_q    <= '0;
            px1_q    <= '0;
            py1_q    <= '0;
            in1_q    <= 1'b0;
            sb1_q    <= '0;
            px2_q    <= '0;
            py2_q    <= '0;
            in2_q    <= 1'b0;
            sb2_q    <= '0;
            ascii3_q <= '0;
            fg3_q    <= '0;
            bg3_q    <= '0;
            px3_q    <= '0;
            in3_q    <= 1'b0;
            sb3_q    <= '0;
            rgb_q    <= '0;
            sb4_q    <= '0;
        end else begin
            chx_q    <= chx_d;
            chy_q    <= chy_d;
            px1_q    <= sx[PX_W-1:0];
            py1_q    <= sy[PY_W-1:0];
            in1_q    <= in1_d;
            sb1_q    <= {de, hsync_in, vsync_in};
            px2_q    <= px1_q;
            py2_q    <= py1_q;
            in2_q    <= in1_q;
            sb2_q    <= sb1_q;
            ascii3_q <= bufferBundle[7:0];
            fg3_q    <= bufferBundle[11:8];
            bg3_q    <= bufferBundle[15:12];
            px3_q    <= px2_q;
            in3_q    <= in2_q;
            sb3_q    <= sb2_q;
            rgb_q    <= rgb_d;
            sb4_q    <= sb3_q;
        end
    end

    // Buffer data arrives here already registered, aligned with py2_q
    assign font_addr = {bufferBundle[6:0], py2_q};

    always_comb begin
        rgb_d = 12'h000;
        if (!sb3_q[2] || !in3_q) begin
            rgb_d = 12'h000;
        end else if (ascii3_q == 8'd0) begin
            rgb_d = palette(bg3_q);
        end else if (ascii3_q == 8'd127) begin
            rgb_d = blink_q ? palette(fg3_q) : palette(bg3_q);
        end else if (ascii3_q[7]) begin
            rgb_d = palette(bg3_q);
        end else begin
            rgb_d = font_row[PX_W'(CH_W - 1) - px3_q] ? palette(fg3_q) : palette(bg3_q);
        end
    end

    // Cursor blink: frame counter advances on each vsync rise
    assign vs_rise = vsync_in & ~vs_prev_q;

    always_comb begin
        frame_d = frame_q;
        blink_d = blink_q;
        if (vs_rise) begin
            if (frame_q == FC_W'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + FC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q <= 1'b0;
            frame_q   <= '0;
            blink_q   <= 1'b1;
        end else begin
            vs_prev_q <= vsync_in;
            frame_q   <= frame_d;
            blink_q   <= blink_d;
        end
    end

    assign chPos_x   = chx_q;
    assign chPos_y   = chy_q;
    assign rgb       = rgb_q;
    assign de_out    = sb4_q[2];
    assign hsync_out = sb4_q[1];
    assign vsync_out = sb4_q[0];

endmodule

// File: tb/tb_text_pixel_renderer.sv
// Directed bench for text_pixel_renderer with behavioural display-buffer and font-ROM models
// and a queue of expected outputs aligned to the pipeline depth.
module tb_text_pixel_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  sx, sy;
    logic        de, hsync_in, vsync_in;
    logic [3:0]  chPos_x;
    logic [2:0]  chPos_y;
    logic [15:0] bufferBundle;
    logic [10:0] font_addr;
    logic [7:0]  font_row;
    logic [11:0] rgb;
    logic        de_out, hsync_out, vsync_out;

    always #5 clk = ~clk;

    text_pixel_renderer dut (
        .clk_pix      (clk),
        .rst_n        (rst_n),
        .sx           (sx),
        .sy           (sy),
        .de           (de),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .chPos_x      (chPos_x),
        .chPos_y      (chPos_y),
        .bufferBundle (bufferBundle),
        .font_addr    (font_addr),
        .font_row     (font_row),
        .rgb          (rgb),
        .de_out       (de_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out)
    );

    logic [15:0] cells [0:4][0:9];

    // Display buffer: one registered read per cycle
    always @(posedge clk)
        bufferBundle <= (chPos_y < 3'd5 && chPos_x < 4'd10) ? cells[chPos_y][chPos_x] : 16'h0;

    // Font ROM: only 'A' row 3 is sparse, everything else reads as solid
    always @(posedge clk)
        font_row <= (font_addr == 11'h413) ? 8'h18 : 8'hFF;

    typedef struct packed {
        logic [11:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        logic [3:0]  chx;
        logic [2:0]  chy;
        logic        ca;
        logic [10:0] addr;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int x, input int y, input logic d, input logic h, input logic v,
                        input logic [11:0] e_rgb, input logic ca, input logic [10:0] ea);
        exp_t e, o;
        @(negedge clk);
        if (q.size() == 4) begin
            o = q.pop_front();
            chk("rgb", {20'd0, rgb}, {20'd0, o.rgb});
            chk("de_out", {31'd0, de_out}, {31'd0, o.de});
            chk("hsync_out", {31'd0, hsync_out}, {31'd0, o.hs});
            chk("vsync_out", {31'd0, vsync_out}, {31'd0, o.vs});
        end else begin
            chk("rgb_after_reset", {20'd0, rgb}, 32'd0);
            chk("de_out_after_reset", {31'd0, de_out}, 32'd0);
        end
        if (q.size() >= 1) begin
            o = q[q.size()-1];
            chk("chPos_x", {28'd0, chPos_x}, {28'd0, o.chx});
            chk("chPos_y", {29'd0, chPos_y}, {29'd0, o.chy});
        end
        if (q.size() >= 2 && q[q.size()-2].ca)
            chk("font_addr", {21'd0, font_addr}, {21'd0, q[q.size()-2].addr});
        sx       = 10'(x);
        sy       = 10'(y);
        de       = d;
        hsync_in = h;
        vsync_in = v;
        e.rgb  = e_rgb;
        e.de   = d;
        e.hs   = h;
        e.vs   = v;
        e.chx  = (x < 80 && y < 80) ? 4'(x / 8) : 4'd0;
        e.chy  = (x < 80 && y < 80) ? 3'(y / 16) : 3'd0;
        e.ca   = ca;
        e.addr = ea;
        q.push_back(e);
    endtask

    task automatic pix(input int x, input int y, input logic [11:0] e_rgb);
        step(x, y, 1'b1, 1'b0, 1'b0, e_rgb, 1'b0, 11'h0);
    endtask

    task automatic idle();
        step(0, 0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 11'h0);
    endtask

    task automatic release_reset();
        sx = '0; sy = '0; de = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        sx = '0; sy = '0; de = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 10; c++)
                cells[r][c] = 16'h0000;
        cells[2][2] = {4'd1, 4'd5, 8'h41};
        cells[0][0] = {4'd5, 4'd5, 8'h41};
        cells[0][9] = {4'd4, 4'd2, 8'h41};
        cells[4][0] = {4'd3, 4'd6, 8'h41};
        cells[1][3] = {4'd4, 4'd5, 8'h00};
        cells[1][4] = {4'd4, 4'd5, 8'h80};
        release_reset();

        // Glyph rendering and font address
        step(19, 35, 1'b1, 1'b0, 1'b0, 12'hFFF, 1'b1, 11'h413);
        step(17, 35, 1'b1, 1'b0, 1'b0, 12'h00F, 1'b1, 11'h413);
        step(19, 35, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 11'h0);
        pix(0, 0, 12'hFFF);

        // Grid boundaries
        pix(80, 10, 12'h000);
        pix(79, 10, 12'h0F0);
        pix(5, 79, 12'hFF0);
        pix(5, 80, 12'h000);

        // Null and high codes fall back to background
        pix(26, 20, 12'hF00);
        pix(36, 20, 12'hF00);

        // Single-cycle sideband pulses
        idle();
        step(0, 0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 11'h0);
        idle();
        pix(19, 35, 12'hFFF);
        idle();
        step(0, 0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 11'h0);
        idle();

        // Asynchronous reset mid-line
        repeat (4) pix(19, 35, 12'hFFF);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rgb", {20'd0, rgb}, 32'd0);
        chk("rst_de_out", {31'd0, de_out}, 32'd0);
        chk("rst_chPos_x", {28'd0, chPos_x}, 32'd0);
        chk("rst_chPos_y", {29'd0, chPos_y}, 32'd0);
        release_reset();

        // Cursor blink over 60 vsync rises
        cells[0][0] = {4'd1, 4'd2, 8'd127};
        for (int f = 0; f <= 60; f++) begin
            pix(0, 0, ((f / 30) % 2 == 0) ? 12'h0F0 : 12'h00F);
            repeat (3) idle();
            if (f < 60) begin
                step(0, 0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 11'h0);
                idle();
            end
        end
        repeat (4) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
